poly_eval_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one serial-load polynomial evaluator (computes A*X*X + B*X + C, mod 256) between NUM_REQ requesters. Each requester presents all four operands in parallel. The block grants one requester and latches its operands. It then drives the evaluator's Go/DataIn load protocol for A, B, C, X in that order, waits for the evaluator's result-valid, and returns the 8-bit result to the granted requester. It sits between the client blocks and the evaluator, which is the only driver of eval_result/eval_valid.

---
 rtl/poly_eval_arbiter.sv | 172 +++++++++++++++++
 tb/tb_poly_eval_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/poly_eval_arbiter.sv
// Round-robin arbiter/sequencer sharing one serial-load evaluator (A*X*X+B*X+C) among NUM_REQ clients.
// Optional watchdog in WAIT_RES compiled in with `define POLY_ARB_TIMEOUT_EN.
module poly_eval_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [8*NUM_REQ-1:0] req_c,
  input  logic [8*NUM_REQ-1:0] req_x,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [7:0]           resp_data,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 eval_go,
  output logic [7:0]           eval_data_in,
  input  logic [7:0]           eval_result,
  input  logic                 eval_valid
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, ARB, GO_HI, GO_LO, WAIT_RES, RESP} state_t;
  typedef logic [3:0][7:0] ops_t;  // [0]=A [1]=B [2]=C [3]=X, load order

  state_t                    state_q, state_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [PW-1:0]             win_q, win_d;
  ops_t                      ops_q, ops_d;
  logic [1:0]                k_q, k_d;
  logic [7:0]                res_q, res_d;
  logic [NUM_REQ-1:0][3:0][7:0] lane_ops;
  logic [PW:0]               scan, win_idx;
  logic                      win_hit;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_ops[g] = {req_x[8*g +: 8], req_c[8*g +: 8], req_b[8*g +: 8], req_a[8*g +: 8]};
  end

  // First asserted request at or after the RR pointer, wrapping.
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    scan    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, ptr_q} + (PW+1)'(i);
      if (scan >= (PW+1)'(NUM_REQ)) scan = scan - (PW+1)'(NUM_REQ);
      if (!win_hit && req[scan]) begin
        win_hit = 1'b1;
        win_idx = scan;
      end
    end
  end

`ifdef POLY_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    ops_d   = ops_q;
    k_d     = k_q;
    res_d   = res_q;
`ifdef POLY_ARB_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (win_hit) begin
          win_d   = win_idx[PW-1:0];
          ops_d   = lane_ops[win_idx];
          ptr_d   = (win_idx == (PW+1)'(NUM_REQ-1)) ? '0 : PW'(win_idx + 1'b1);
          k_d     = 2'd0;
          state_d = GO_HI;
        end else begin
          state_d = IDLE;
        end
      end
      GO_HI: state_d = GO_LO;
      GO_LO: begin
        if (k_q == 2'd3) begin
          state_d = WAIT_RES;
`ifdef POLY_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          k_d     = k_q + 2'd1;
          state_d = GO_HI;
        end
      end
      WAIT_RES: begin
        if (eval_valid) begin
          res_d   = eval_result;
          state_d = RESP;
`ifdef POLY_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          res_d   = 8'h00;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d   = tmo_q + 1'b1;
`endif
        end
      end
      RESP:    state_d = (|req) ? ARB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      ops_q   <= '0;
      k_q     <= '0;
      res_q   <= '0;
`ifdef POLY_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      ops_q   <= ops_d;
      k_q     <= k_d;
      res_q   <= res_d;
`ifdef POLY_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  // Grant is combinational in ARB so it is visible in the decision cycle.
  always_comb begin
    gnt        = '0;
    resp_valid = '0;
    case (state_q)
      ARB:                     if (win_hit) gnt[win_idx] = 1'b1;
      GO_HI, GO_LO, WAIT_RES:  gnt[win_q] = 1'b1;
      RESP: begin
        gnt[win_q]        = 1'b1;
        resp_valid[win_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign resp_data    = (state_q == RESP) ? res_q : 8'h00;
`ifdef POLY_ARB_TIMEOUT_EN
  assign resp_err     = (state_q == RESP) && err_q;
`else
  assign resp_err     = 1'b0;
`endif
  assign busy         = (state_q != IDLE);
  assign eval_go      = (state_q == GO_HI);
  // k and the operand latch only move in ARB/GO_LO, so this holds the last value elsewhere.
  assign eval_data_in = ops_q[k_q];

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Scoreboard bench for poly_eval_arbiter with a behavioural serial-load evaluator.
module tb_poly_eval_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_a, req_b, req_c, req_x;
  logic [N-1:0]   gnt, resp_valid;
  logic [7:0]     resp_data, eval_data_in, eval_result;
  logic           resp_err, busy, eval_go, eval_valid;

  poly_eval_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_x(req_x),
    .gnt(gnt), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .eval_go(eval_go), .eval_data_in(eval_data_in),
    .eval_result(eval_result), .eval_valid(eval_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Evaluator model: loads on Go rising edge, valid 5 cycles after the last GO_LO.
  logic       go_q;
  int         n_ld, dly;
  logic [7:0] ea, eb, ec, ex;
  logic       eval_dead = 1'b0;
  logic [7:0] ld_q[$];

  always @(posedge clk) begin
    go_q <= eval_go;
    if (reset) begin
      go_q <= 1'b0; n_ld <= 0; dly <= 0;
      eval_valid <= 1'b0; eval_result <= 8'h00;
    end else begin
      if (dly > 0) begin
        dly <= dly - 1;
        if (dly == 1 && !eval_dead) begin
          eval_valid  <= 1'b1;
          eval_result <= 8'(ea * ex * ex + eb * ex + ec);
        end
      end
      if (eval_go && !go_q) begin
        eval_valid <= 1'b0;
        ld_q.push_back(eval_data_in);
        case (n_ld)
          0: ea <= eval_data_in;
          1: eb <= eval_data_in;
          2: ec <= eval_data_in;
          default: begin ex <= eval_data_in; dly <= 5; end
        endcase
        n_ld <= (n_ld + 1) % 4;
      end
    end
  end

  typedef struct { int idx; logic [7:0] data; logic err; } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;
  int last_resp_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each response; checks grant hold while loading.
  always @(negedge clk) begin
    if (!reset) begin
      if (|resp_valid) begin
        if (sb.size() == 0) chk("unexpected_resp", 32'(resp_valid), 0);
        else begin
          e = sb.pop_front();
          chk("resp_valid", 32'(resp_valid), 32'(1 << e.idx));
          chk("resp_data", 32'(resp_data), 32'(e.data));
          chk("resp_err", 32'(resp_err), 32'(e.err));
          last_resp_cyc = cyc;
        end
      end
      if (eval_go && sb.size() > 0) chk("gnt_hold", 32'(gnt), 32'(1 << sb[0].idx));
    end
  end

  task automatic set_ops(input int i, input logic [7:0] a, b, c, x);
    req_a[8*i +: 8] = a; req_b[8*i +: 8] = b;
    req_c[8*i +: 8] = c; req_x[8*i +: 8] = x;
  endtask

  task automatic expect_resp(input int i, input logic [7:0] d, input logic er);
    exp_t t;
    t.idx = i; t.data = d; t.err = er;
    sb.push_back(t);
  endtask

  // Waits for all expected responses; requesters drop req after their response.
  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      req = req & ~resp_valid;
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, n;
    reset = 1'b1; req = '0; req_a = '0; req_b = '0; req_c = '0; req_x = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Reset state
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_eval_go", 32'(eval_go), 0);
    chk("rst_eval_data_in", 32'(eval_data_in), 0);

    // Single request: 1*4+2*2+3 = 11
    set_ops(0, 1, 2, 3, 2);
    ld_q.delete();
    expect_resp(0, 8'd11, 1'b0);
    req = 4'b0001; t0 = cyc;
    drain(100);
    chk("t1_latency", 32'(last_resp_cyc - t0), 15);
    chk("t1_loads", 32'(ld_q.size()), 4);
    if (ld_q.size() == 4) begin
      chk("t1_ld_a", 32'(ld_q[0]), 1);
      chk("t1_ld_b", 32'(ld_q[1]), 2);
      chk("t1_ld_c", 32'(ld_q[2]), 3);
      chk("t1_ld_x", 32'(ld_q[3]), 2);
    end
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 0);

    // Wrap arithmetic: 300+50+7 = 357 -> 101
    set_ops(2, 3, 5, 7, 10);
    expect_resp(2, 8'd101, 1'b0);
    req = 4'b0100;
    drain(100);

    // Round-robin from pointer 0: X=i, A=B=C=1 -> 1,3,7,13
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 1, 1, 1, 8'(i));
    expect_resp(0, 8'd1, 1'b0);
    expect_resp(1, 8'd3, 1'b0);
    expect_resp(2, 8'd7, 1'b0);
    expect_resp(3, 8'd13, 1'b0);
    req = 4'b1111;
    drain(300);
    chk("rr_req_cleared", 32'(req), 0);

    // Reset during GO_LO of operand C abandons the job
    set_ops(1, 4, 4, 4, 4);
    req = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (!(n_ld == 3 && !eval_go && busy) && n < 50);
    chk("rst_mid_reached", 32'(n < 50), 1);
    reset = 1'b1; req = '0;
    @(negedge clk) reset = 1'b0;
    chk("rst_mid_gnt", 32'(gnt), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_resp_valid", 32'(resp_valid), 0);
    set_ops(1, 2, 0, 5, 3);  // 2*9+5 = 23
    expect_resp(1, 8'd23, 1'b0);
    req = 4'b0010;
    drain(100);

    // Withdrawn request during WAIT_RES still completes: 4*6+9 = 33
    set_ops(1, 0, 4, 9, 6);
    ld_q.delete();
    expect_resp(1, 8'd33, 1'b0);
    req = 4'b0010;
    n = 0;
    while (ld_q.size() < 4 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk) req = '0;
    drain(100);
    @(negedge clk);
    chk("wd_busy", 32'(busy), 0);
    chk("wd_gnt", 32'(gnt), 0);

`ifdef POLY_ARB_TIMEOUT_EN
    // Evaluator never answers: RESP after 32 WAIT_RES cycles with error
    eval_dead = 1'b1;
    set_ops(0, 1, 1, 1, 1);
    expect_resp(0, 8'h00, 1'b1);
    req = 4'b0001; t0 = cyc;
    drain(200);
    chk("tmo_latency", 32'(last_resp_cyc - t0), 42);
    eval_dead = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
